// File: rtl/spi_bitrev_pkg.sv
// spi_bitrev_pkg: states, mode codes and the response transform for spi_bitrev_slave.
package spi_bitrev_pkg;
  typedef enum logic [1:0] {IDLE, RX, TX, DONE} state_t;
  localparam logic [1:0] MODE_ECHO   = 2'b00;
  localparam logic [1:0] MODE_REV    = 2'b01;
  localparam logic [1:0] MODE_INV    = 2'b10;
  localparam logic [1:0] MODE_REVINV = 2'b11;
  // Works on the low w bits of a 64-bit container, so frames up to 64 bits are supported.
  function automatic logic [63:0] xform(input logic [63:0] word, input logic [1:0] mode, input int w);
    logic [63:0] r;
    logic rev, inv;
    rev = (mode == MODE_REV) || (mode == MODE_REVINV);
    inv = (mode == MODE_INV) || (mode == MODE_REVINV);
    r = '0;
    for (int i = 0; i < 64; i++)
      if (i < w) r[i] = (rev ? word[w-1-i] : word[i]) ^ inv;
    return r;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-stage synchroniser with rise/fall pulses, suppressed until the pipe holds real samples.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES:0] r_sync, r_vld;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_sync <= {(STAGES+1){RST_VAL}};
      r_vld  <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-1:0], i_d};
      r_vld  <= {r_vld[STAGES-1:0], 1'b1};
    end
  // A pin already at the opposite level during reset must not look like an edge.
  assign o_rise = r_vld[STAGES] & r_sync[STAGES-1] & ~r_sync[STAGES];
  assign o_fall = r_vld[STAGES] & ~r_sync[STAGES-1] & r_sync[STAGES];
endmodule

// File: rtl/spi_bitrev_slave.sv
// spi_bitrev_slave: oversampled SPI mode-0 slave returning echo/reverse/invert of each frame.
// Define SPI_BITREV_ERR_EN to add the sticky o_err abort/overlength flag.
module spi_bitrev_slave
  import spi_bitrev_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sck,
  input  logic              i_ss,
  input  logic              i_mosi,
  input  logic [1:0]        i_mode,
  output logic              o_miso,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_frame_done,
  output logic              o_busy
`ifdef SPI_BITREV_ERR_EN
  ,
  output logic              o_err
`endif
);
  localparam int CW = $clog2(DATA_W) + 1;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [DATA_W-1:0]      r_rx, r_tx;
  logic [1:0]             r_mode;
  logic [SYNC_STAGES-1:0] r_mosi;
  logic                   w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall, w_mosi, w_last;
  logic [DATA_W-1:0]      w_word;
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_sck), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_ss), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );
  always_ff @(posedge i_clk)
    if (i_rst) r_mosi <= '0;
    else r_mosi <= {r_mosi[SYNC_STAGES-2:0], i_mosi};
  assign w_mosi = r_mosi[SYNC_STAGES-1];
  assign w_word = {r_rx[DATA_W-2:0], w_mosi};
  assign w_last = r_cnt == CW'(DATA_W - 1);
  assign o_busy = (r_state == RX) || (r_state == TX);
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rx         <= '0;
      r_tx         <= '0;
      r_mode       <= MODE_ECHO;
      o_miso       <= 1'b1;
      o_rx_data    <= '0;
      o_frame_done <= 1'b0;
`ifdef SPI_BITREV_ERR_EN
      o_err        <= 1'b0;
`endif
    end else begin
      o_frame_done <= 1'b0;
      case (r_state)
        IDLE:
          if (w_ss_fall) begin
            r_state <= RX;
            r_cnt   <= '0;
            r_rx    <= '0;
            r_mode  <= i_mode;
          end
        RX, TX:
          if (w_ss_rise) begin
            r_state <= IDLE;
            o_miso  <= 1'b1;
`ifdef SPI_BITREV_ERR_EN
            o_err   <= 1'b1;
`endif
          end else if (r_state == RX) begin
            if (w_sck_rise) begin
              r_rx  <= w_word;
              r_cnt <= w_last ? '0 : r_cnt + 1'b1;
              if (w_last) begin
                o_rx_data <= w_word;
                r_tx      <= DATA_W'(xform(64'(w_word), r_mode, DATA_W));
                r_state   <= TX;
              end
            end
          end else begin
            if (w_sck_fall) begin
              o_miso <= r_tx[DATA_W-1];
              r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
            end
            if (w_sck_rise) begin
              r_cnt <= r_cnt + 1'b1;
              if (w_last) begin
                o_frame_done <= 1'b1;
                o_miso       <= 1'b1;
                r_state      <= DONE;
              end
            end
          end
        DONE:
          if (w_ss_rise) r_state <= IDLE;
`ifdef SPI_BITREV_ERR_EN
          else if (w_sck_rise) o_err <= 1'b1;
`endif
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_bitrev_slave.sv
// tb_spi_bitrev_slave: directed frames on a shared SPI bus against an 8-bit and a 16-bit slave.
module tb_spi_bitrev_slave;
  localparam int H = 6;
  logic clk = 1'b0, rst = 1'b1, sck = 1'b0, mosi = 1'b0, ss8 = 1'b1, ss16 = 1'b1;
  logic [1:0] mode = 2'b00;
  logic miso8, miso16, fd8, fd16, busy8, busy16;
  logic [7:0] rx8;
  logic [15:0] rx16;
`ifdef SPI_BITREV_ERR_EN
  logic err8, err16;
`endif
  int total = 0, bad = 0, fd_cnt8 = 0, fd_cnt16 = 0;
  logic chk_on = 1'b0, prev8 = 1'b0, prev16 = 1'b0;
  logic [15:0] exp_rx8 = '0, exp_rx16 = '0;
  always #5 clk = ~clk;
  spi_bitrev_slave #(.DATA_W(8), .SYNC_STAGES(2)) u_d8 (
    .i_clk(clk), .i_rst(rst), .i_sck(sck), .i_ss(ss8), .i_mosi(mosi), .i_mode(mode),
    .o_miso(miso8), .o_rx_data(rx8), .o_frame_done(fd8), .o_busy(busy8)
`ifdef SPI_BITREV_ERR_EN
    , .o_err(err8)
`endif
  );
  spi_bitrev_slave #(.DATA_W(16), .SYNC_STAGES(2)) u_d16 (
    .i_clk(clk), .i_rst(rst), .i_sck(sck), .i_ss(ss16), .i_mosi(mosi), .i_mode(mode),
    .o_miso(miso16), .o_rx_data(rx16), .o_frame_done(fd16), .o_busy(busy16)
`ifdef SPI_BITREV_ERR_EN
    , .o_err(err16)
`endif
  );
  task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  // Expected response from plain arithmetic: reverse by peeling bits, invert by subtraction.
  function automatic logic [15:0] model(input logic [15:0] v, input logic [1:0] m, input int w);
    int x, r;
    x = int'(v);
    r = x;
    if (m[0]) begin
      r = 0;
      for (int i = 0; i < w; i++) begin
        r = r * 2 + x % 2;
        x = x / 2;
      end
    end
    if (m[1]) r = (1 << w) - 1 - r;
    return r[15:0];
  endfunction
  always @(negedge clk)
    if (chk_on && !rst) begin
      if (!busy8) begin
        chk("idle_miso8", {15'd0, miso8}, 16'd1);
        chk("rx8", {8'd0, rx8}, exp_rx8);
      end
      if (!busy16) begin
        chk("idle_miso16", {15'd0, miso16}, 16'd1);
        chk("rx16", rx16, exp_rx16);
      end
      chk("fd8_width", {15'd0, prev8 & fd8}, 16'd0);
      chk("fd16_width", {15'd0, prev16 & fd16}, 16'd0);
      fd_cnt8 += int'(fd8);
      fd_cnt16 += int'(fd16);
      prev8 = fd8;
      prev16 = fd16;
    end
  task automatic pulse(input bit wide, input logic b, output logic s);
    mosi = b;
    repeat (H) @(negedge clk);
    sck = 1'b1;
    s = wide ? miso16 : miso8;
    repeat (H) @(negedge clk);
    sck = 1'b0;
  endtask
  task automatic xfer(input bit wide, input int n, input logic [15:0] tx, input logic [1:0] m0,
                      input logic [1:0] m1, output logic [15:0] got);
    int w;
    logic s;
    w = wide ? 16 : 8;
    got = '0;
    mode = m0;
    if (wide) ss16 = 1'b0; else ss8 = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i == 3) mode = m1;
      pulse(wide, i < w ? tx[w-1-i] : 1'b0, s);
      if (i >= w && i < 2 * w) got = {got[14:0], s};
      if (i == w - 1) begin
        if (wide) exp_rx16 = tx; else exp_rx8 = tx;
      end
    end
    repeat (H) @(negedge clk);
    if (wide) ss16 = 1'b1; else ss8 = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask
  initial begin
    logic [15:0] got;
    logic [7:0] v;
    logic s, all_one;
    int f0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_miso8", {15'd0, miso8}, 16'd1);
    chk("rst_rx8", {8'd0, rx8}, 16'd0);
    chk("rst_fd8", {15'd0, fd8}, 16'd0);
    chk("rst_busy8", {15'd0, busy8}, 16'd0);
    chk("rst_rx16", rx16, 16'd0);
`ifdef SPI_BITREV_ERR_EN
    chk("rst_err8", {15'd0, err8}, 16'd0);
`endif
    chk_on = 1'b1;
    f0 = fd_cnt8;
    xfer(1'b0, 16, 16'h01, 2'b01, 2'b01, got);
    chk("rev_01", got, 16'h0080);
    chk("rev_01_model", got, model(16'h01, 2'b01, 8));
    chk("rev_01_rx", {8'd0, rx8}, 16'h0001);
    chk("rev_01_fd", 16'(fd_cnt8 - f0), 16'd1);
    xfer(1'b0, 16, 16'hA5, 2'b00, 2'b00, got);
    chk("echo_a5", got, 16'h00A5);
    chk("echo_a5_model", got, model(16'hA5, 2'b00, 8));
    xfer(1'b0, 16, 16'h0F, 2'b11, 2'b11, got);
    chk("revinv_0f", got, 16'h000F);
    chk("revinv_0f_model", got, model(16'h0F, 2'b11, 8));
    chk("model_inv_pin", model(16'h12, 2'b10, 8), 16'h00ED);
    xfer(1'b0, 16, 16'h3C, 2'b01, 2'b10, got);
    chk("mode_latched", got, 16'h003C);
    chk("mode_latched_model", got, model(16'h3C, 2'b01, 8));
    f0 = fd_cnt8;
    xfer(1'b0, 4, 16'h55, 2'b00, 2'b00, got);
    chk("abort_fd", 16'(fd_cnt8 - f0), 16'd0);
    chk("abort_rx", {8'd0, rx8}, 16'h003C);
`ifdef SPI_BITREV_ERR_EN
    chk("abort_err", {15'd0, err8}, 16'd1);
`endif
    xfer(1'b0, 16, 16'h81, 2'b01, 2'b01, got);
    chk("after_abort", got, 16'h0081);
    f0 = fd_cnt8;
    v = 8'hAA;
    mode = 2'b01;
    ss8 = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      pulse(1'b0, i < 8 ? v[7-i] : 1'b0, s);
      if (i == 7) exp_rx8 = 16'h00AA;
    end
    exp_rx8 = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_tx_busy", {15'd0, busy8}, 16'd0);
    chk("rst_tx_rx", {8'd0, rx8}, 16'd0);
`ifdef SPI_BITREV_ERR_EN
    chk("rst_tx_err", {15'd0, err8}, 16'd0);
`endif
    all_one = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pulse(1'b0, 1'b0, s);
      all_one &= s;
    end
    chk("rst_no_resp", {15'd0, all_one}, 16'd1);
    chk("rst_no_fd", 16'(fd_cnt8 - f0), 16'd0);
    ss8 = 1'b1;
    repeat (2 * H) @(negedge clk);
    xfer(1'b0, 16, 16'hC3, 2'b10, 2'b10, got);
    chk("post_rst", got, 16'h003C);
    f0 = fd_cnt16;
    xfer(1'b1, 33, 16'h0001, 2'b01, 2'b01, got);
    chk("w16_rev", got, 16'h8000);
    chk("w16_rev_model", got, model(16'h0001, 2'b01, 16));
    chk("w16_rx", rx16, 16'h0001);
    chk("w16_fd", 16'(fd_cnt16 - f0), 16'd1);
    chk("w16_miso", {15'd0, miso16}, 16'd1);
`ifdef SPI_BITREV_ERR_EN
    chk("w16_err", {15'd0, err16}, 16'd1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
